// File: rtl/routine_sequencer.sv
// Routine sequencer: picks one of NUM_ROUTINES light-routine buses, drives the
// board pins from it, and steps through routines on done pulses or Advance edges.
module routine_sequencer #(
  parameter int unsigned NUM_ROUTINES = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned HOLD_CYCLES  = 2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [47*NUM_ROUTINES-1:0]  BusIn,
  input  logic                        Advance,
  input  logic                        AutoEn,
  output logic [NUM_ROUTINES-1:0]     RoutineReset,
  output logic [IDX_W-1:0]            ActiveIdx,
  output logic [9:0]                  LedRed,
  output logic [7:0]                  LedGrn,
  output logic [6:0]                  Hex3,
  output logic [6:0]                  Hex2,
  output logic [6:0]                  Hex1,
  output logic [6:0]                  Hex0
);

  localparam int unsigned SLICE_W = 47;
  localparam int unsigned CNT_W   = $clog2(HOLD_CYCLES) + 1;

  typedef struct packed {
    logic [9:0] red;
    logic [7:0] grn;
    logic [6:0] hex3;
    logic [6:0] hex2;
    logic [6:0] hex1;
    logic [6:0] hex0;
  } disp_t;

  typedef struct packed {
    logic  done;
    disp_t disp;
  } slice_t;

  typedef enum logic {
    RUN    = 1'b0,
    SWITCH = 1'b1
  } state_e;

  localparam disp_t BLANK = '{red: 10'h000, grn: 8'h00,
                              hex3: 7'h7F, hex2: 7'h7F, hex1: 7'h7F, hex0: 7'h7F};

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    adv_prev_q, adv_prev_d;
  logic [NUM_ROUTINES-1:0] rr_q, rr_d;
  disp_t                   disp_q, disp_d;

  slice_t                  active_slice;
  logic                    adv_edge;
  logic                    trigger;

  // Mux out the slice of the currently selected routine.
  always_comb begin
    active_slice = '0;
    for (int unsigned k = 0; k < NUM_ROUTINES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        active_slice = BusIn[SLICE_W*k +: SLICE_W];
      end
    end
  end

  assign adv_edge = Advance & ~adv_prev_q;
  assign trigger  = adv_edge | (AutoEn & active_slice.done);

  // Next-state and next-output logic; outputs stay blank except in steady RUN.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    adv_prev_d = Advance;
    disp_d     = BLANK;
    rr_d       = '1;

    unique case (state_q)
      RUN: begin
        if (trigger) begin
          state_d = SWITCH;
          idx_d   = (idx_q == IDX_W'(NUM_ROUTINES - 1)) ? '0 : idx_q + IDX_W'(1);
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          disp_d = active_slice.disp;
        end
      end
      SWITCH: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = SWITCH;
        idx_d   = '0;
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      end
    endcase

    // Registered reset mask tracks the state being entered.
    if (state_d == RUN) begin
      rr_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= SWITCH;
      idx_q      <= '0;
      cnt_q      <= CNT_W'(HOLD_CYCLES - 1);
      adv_prev_q <= 1'b0;
      rr_q       <= '1;
      disp_q     <= BLANK;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      adv_prev_q <= adv_prev_d;
      rr_q       <= rr_d;
      disp_q     <= disp_d;
    end
  end

  assign RoutineReset = rr_q;
  assign ActiveIdx    = idx_q;
  assign LedRed       = disp_q.red;
  assign LedGrn       = disp_q.grn;
  assign Hex3         = disp_q.hex3;
  assign Hex2         = disp_q.hex2;
  assign Hex1         = disp_q.hex1;
  assign Hex0         = disp_q.hex0;

endmodule

// File: tb/tb_routine_sequencer.sv
// Bench for routine_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_routine_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned HOLD = 2;
  localparam int unsigned SW   = 47;
  localparam logic [45:0] BLANK = {18'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  logic            Clock = 1'b0;
  logic            Reset;
  logic            Advance;
  logic            AutoEn;
  logic [SW*N-1:0] BusIn;
  logic [N-1:0]    RoutineReset;
  logic [IW-1:0]   ActiveIdx;
  logic [9:0]      LedRed;
  logic [7:0]      LedGrn;
  logic [6:0]      Hex3, Hex2, Hex1, Hex0;

  int checks   = 0;
  int failures = 0;

  // Model: selected routine, remaining blank cycles, last Advance level, pins.
  int          m_idx  = 0;
  int          m_hold = 0;
  bit          m_prev = 1'b0;
  logic [45:0] m_disp = BLANK;

  routine_sequencer #(
    .NUM_ROUTINES(N),
    .IDX_W       (IW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BusIn       (BusIn),
    .Advance     (Advance),
    .AutoEn      (AutoEn),
    .RoutineReset(RoutineReset),
    .ActiveIdx   (ActiveIdx),
    .LedRed      (LedRed),
    .LedGrn      (LedGrn),
    .Hex3        (Hex3),
    .Hex2        (Hex2),
    .Hex1        (Hex1),
    .Hex0        (Hex0)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [46:0] mk(input logic done, input logic [9:0] red,
                                     input logic [7:0] grn, input logic [6:0] h3,
                                     input logic [6:0] h2, input logic [6:0] h1,
                                     input logic [6:0] h0);
    return {done, red, grn, h3, h2, h1, h0};
  endfunction

  task automatic set_slice(input int k, input logic [46:0] v);
    BusIn[SW*k +: SW] = v;
  endtask

  task automatic set_done(input int k, input logic d);
    BusIn[SW*k + 46] = d;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  function automatic void model_step();
    bit          edge_seen;
    logic [46:0] s;
    edge_seen = Advance && !m_prev;
    if (Reset) begin
      m_idx  = 0;
      m_hold = HOLD;
      m_prev = 1'b0;
      m_disp = BLANK;
      return;
    end
    m_prev = Advance;
    if (m_hold > 0) begin
      m_hold = m_hold - 1;
      m_disp = BLANK;
    end else begin
      s = BusIn[SW*m_idx +: SW];
      if (edge_seen || (AutoEn && s[46])) begin
        m_idx  = (m_idx + 1) % N;
        m_hold = HOLD;
        m_disp = BLANK;
      end else begin
        m_disp = s[45:0];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    logic [N-1:0] rr;
    @(posedge Clock);
    model_step();
    #1;
    rr = '1;
    if (m_hold == 0) rr[m_idx] = 1'b0;
    chk("active_idx",    64'(ActiveIdx),    64'(m_idx));
    chk("routine_reset", 64'(RoutineReset), 64'(rr));
    chk("led_red",       64'(LedRed),       64'(m_disp[45:36]));
    chk("led_grn",       64'(LedGrn),       64'(m_disp[35:28]));
    chk("hex3",          64'(Hex3),         64'(m_disp[27:21]));
    chk("hex2",          64'(Hex2),         64'(m_disp[20:14]));
    chk("hex1",          64'(Hex1),         64'(m_disp[13:7]));
    chk("hex0",          64'(Hex0),         64'(m_disp[6:0]));
  endtask

  task automatic pulse_adv();
    Advance = 1'b1;
    cyc();
    Advance = 1'b0;
    repeat (HOLD + 1) cyc();
  endtask

  initial begin
    logic [46:0] v;
    Reset   = 1'b1;
    Advance = 1'b0;
    AutoEn  = 1'b0;
    BusIn   = '0;
    set_slice(0, mk(1'b0, 10'h3C0, 8'h5A, 7'h01, 7'h02, 7'h03, 7'h04));
    set_slice(1, mk(1'b0, 10'h155, 8'hA5, 7'h11, 7'h12, 7'h13, 7'h14));
    set_slice(2, mk(1'b0, 10'h2AA, 8'h3C, 7'h21, 7'h22, 7'h23, 7'h24));
    set_slice(3, mk(1'b0, 10'h0F0, 8'hC3, 7'h31, 7'h32, 7'h33, 7'h34));

    // Reset, then the initial blank hold and first routine output.
    repeat (3) cyc();
    chk("reset_rr",  64'(RoutineReset), 64'(4'hF));
    chk("reset_hex", 64'(Hex0),         64'(7'h7F));
    Reset = 1'b0;
    cyc();
    chk("hold_rr", 64'(RoutineReset), 64'(4'hF));
    cyc();
    chk("run0_rr",  64'(RoutineReset), 64'(4'hE));
    chk("run0_hex", 64'(Hex3),          64'(7'h7F));
    cyc();
    chk("first_red", 64'(LedRed), 64'(10'h3C0));

    // Auto advance on the active routine's done pulse.
    AutoEn = 1'b1;
    set_done(0, 1'b1);
    cyc();
    set_done(0, 1'b0);
    chk("auto_idx",   64'(ActiveIdx), 64'(1));
    chk("auto_blank", 64'(LedRed),    64'(0));
    cyc();
    cyc();
    chk("auto_rr", 64'(RoutineReset), 64'(4'hD));
    cyc();
    chk("auto_red", 64'(LedRed), 64'(10'h155));

    // Done ignored when auto is off, and on inactive slices.
    AutoEn = 1'b0;
    set_done(1, 1'b1);
    cyc();
    set_done(1, 1'b0);
    cyc();
    chk("autooff_idx", 64'(ActiveIdx), 64'(1));
    AutoEn = 1'b1;
    set_done(2, 1'b1);
    repeat (3) cyc();
    set_done(2, 1'b0);
    chk("inactive_done_idx", 64'(ActiveIdx), 64'(1));

    // Held Advance gives exactly one step, 3 -> 0.
    pulse_adv();
    pulse_adv();
    chk("reach3_idx", 64'(ActiveIdx), 64'(3));
    Advance = 1'b1;
    repeat (10) cyc();
    chk("held_adv_idx", 64'(ActiveIdx), 64'(0));
    Advance = 1'b0;
    cyc();

    // A second rising edge inside the blank hold is dropped.
    Advance = 1'b1;
    cyc();
    Advance = 1'b0;
    cyc();
    Advance = 1'b1;
    cyc();
    Advance = 1'b0;
    repeat (3) cyc();
    chk("switch_edge_ignored", 64'(ActiveIdx), 64'(1));

    // Advance edge coinciding with done counts once.
    Advance = 1'b1;
    set_done(1, 1'b1);
    cyc();
    Advance = 1'b0;
    set_done(1, 1'b0);
    chk("dual_trigger_idx", 64'(ActiveIdx), 64'(2));
    repeat (HOLD + 1) cyc();
    chk("dual_trigger_settle", 64'(ActiveIdx), 64'(2));

    // Reset during the first blank cycle of 2 -> 3 restarts from routine 0.
    Advance = 1'b1;
    cyc();
    Advance = 1'b0;
    chk("pre_reset_idx", 64'(ActiveIdx), 64'(3));
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("mid_reset_idx", 64'(ActiveIdx),    64'(0));
    chk("mid_reset_rr",  64'(RoutineReset), 64'(4'hF));
    cyc();
    chk("mid_reset_hold", 64'(RoutineReset), 64'(4'hF));
    cyc();
    chk("mid_reset_run", 64'(RoutineReset), 64'(4'hE));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      Reset = ($urandom % 150) == 0;
      if (($urandom % 5) == 0) Advance = ~Advance;
      if (($urandom % 25) == 0) AutoEn = ~AutoEn;
      for (int k = 0; k < N; k++) begin
        v = {1'(($urandom % 8) == 0), 10'($urandom), 8'($urandom),
             7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
        set_slice(k, v);
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
